bcm_stdp_array: RTL and testbench

- Parametrised multi-synapse trace-based STDP/BCM plasticity engine.
- N_SYN presynaptic spike channels converge on one postsynaptic neuron. The block keeps one presynaptic trace per channel, a fast postsynaptic trace and an optional slow postsynaptic trace.
- Each channel owns one signed weight, updated on spike edges.
- Successor of the single-synapse BCM block. Feeds the neuron core's synaptic-current summation.

---
 rtl/bcm_stdp_array.sv | 184 ++++++++++++++++++
 tb/tb_bcm_stdp_array.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcm_stdp_array.sv
// Multi-synapse trace-based STDP/BCM plasticity engine: N_SYN presynaptic channels onto one neuron.
// Optional triplet potentiation term (live slow trace o2) enabled by `define BCM_STDP_TRIPLET_EN.

// One saturating exponential-decay trace; decay floors at 1 so the trace settles at exactly 0.
module bcm_stdp_trace #(
  parameter int W     = 18,
  parameter int INC   = 1024,
  parameter int SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spike,
  input  logic                tick,
  output logic signed [W-1:0] t
);
  localparam logic signed [W+1:0] TMAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] INC_V = (W+2)'(INC);

  logic signed [W-1:0] dec, tn;
  logic signed [W+1:0] sum;

  always_comb begin
    dec = '0;
    if (tick) begin
      dec = t >>> SHIFT;
      if (dec == '0 && t != '0) dec = {{(W-1){1'b0}}, 1'b1};
    end
    sum = {{2{t[W-1]}}, t} - {{2{dec[W-1]}}, dec} + (spike ? INC_V : '0);
    if (sum[W+1])        tn = '0;
    else if (sum > TMAX) tn = TMAX[W-1:0];
    else                 tn = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) t <= '0;
    else     t <= tn;
  end
endmodule

// Per-channel presynaptic trace plus weight with pair (and optional triplet) update.
module bcm_stdp_lane #(
  parameter int W         = 18,
  parameter int INC       = 1024,
  parameter int TAU_SHIFT = 3,
  parameter int AP        = 4,
  parameter int AM        = 5,
  parameter int TRIP_SH   = 14,
  parameter int W_INIT    = 4096,
  parameter int W_MIN     = 0,
  parameter int W_MAX     = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn_en,
  input  logic                pre_edge,
  input  logic                post_edge,
  input  logic                tick,
  input  logic signed [W-1:0] o1,
`ifdef BCM_STDP_TRIPLET_EN
  input  logic signed [W-1:0] o2,
`endif
  output logic signed [W-1:0] w,
  output logic signed [W-1:0] r1,
  output logic                chg
);
  localparam logic signed [W+1:0] WLO    = (W+2)'(W_MIN);
  localparam logic signed [W+1:0] WHI    = (W+2)'(W_MAX);
  localparam logic signed [W-1:0] WINI_V = W'(W_INIT);

  logic signed [W-1:0] dp_pair, dm, wn;
  logic signed [W+1:0] dp, wsum;
`ifdef BCM_STDP_TRIPLET_EN
  logic signed [2*W-1:0] prod;
`endif

  bcm_stdp_trace #(.W(W), .INC(INC), .SHIFT(TAU_SHIFT)) u_r1 (
    .clk(clk), .rst(rst), .spike(pre_edge), .tick(tick), .t(r1)
  );

  // r1/o1/o2 here are the register outputs, i.e. the pre-spike trace values
  always_comb begin
    dp_pair = r1 >>> AP;
    dm      = o1 >>> AM;
    dp      = '0;
    if (post_edge) dp = {{2{dp_pair[W-1]}}, dp_pair};
`ifdef BCM_STDP_TRIPLET_EN
    prod = r1 * o2;
    if (post_edge) dp = dp + (W+2)'(prod >>> TRIP_SH);
`endif
    wsum = {{2{w[W-1]}}, w} + dp - (pre_edge ? {{2{dm[W-1]}}, dm} : '0);
    if (wsum < WLO)      wn = WLO[W-1:0];
    else if (wsum > WHI) wn = WHI[W-1:0];
    else                 wn = wsum[W-1:0];
    chg = learn_en && (wn != w);
  end

  always_ff @(posedge clk) begin
    if (rst)           w <= WINI_V;
    else if (learn_en) w <= wn;
  end
endmodule

module bcm_stdp_array #(
  parameter int N_SYN         = 4,
  parameter int W_WIDTH       = 18,
  parameter int FRAC          = 10,
  parameter int TRACE_INC     = 1024,
  parameter int TAU_SHIFT     = 3,
  parameter int DECAY_DIV     = 1,
  parameter int A_PLUS_SHIFT  = 4,
  parameter int A_MINUS_SHIFT = 5,
  parameter int W_INIT        = 4096,
  parameter int W_MIN         = 0,
  parameter int W_MAX         = 16384
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       learn_en,
  input  logic [N_SYN-1:0]           pre,
  input  logic                       post,
  output logic [N_SYN*W_WIDTH-1:0]   w_bus,
  output logic [N_SYN*W_WIDTH-1:0]   r1_bus,
  output logic [W_WIDTH-1:0]         o1,
  output logic [W_WIDTH-1:0]         o2,
  output logic                       upd_valid
);
  localparam logic [15:0] DIV_LAST = 16'(DECAY_DIV - 1);

  logic [N_SYN-1:0]          pre_q, pre_edge, chg;
  logic                      post_q, post_edge, tick;
  logic [15:0]               div_cnt;
  logic signed [W_WIDTH-1:0] o1_t;

  assign pre_edge  = pre & ~pre_q;
  assign post_edge = post & ~post_q;
  assign tick      = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      post_q    <= 1'b0;
      div_cnt   <= '0;
      upd_valid <= 1'b0;
    end else begin
      pre_q     <= pre;
      post_q    <= post;
      div_cnt   <= tick ? '0 : div_cnt + 16'd1;
      upd_valid <= |chg;
    end
  end

  bcm_stdp_trace #(.W(W_WIDTH), .INC(TRACE_INC), .SHIFT(TAU_SHIFT)) u_o1 (
    .clk(clk), .rst(rst), .spike(post_edge), .tick(tick), .t(o1_t)
  );
  assign o1 = o1_t;

`ifdef BCM_STDP_TRIPLET_EN
  logic signed [W_WIDTH-1:0] o2_t;
  bcm_stdp_trace #(.W(W_WIDTH), .INC(TRACE_INC), .SHIFT(TAU_SHIFT + 2)) u_o2 (
    .clk(clk), .rst(rst), .spike(post_edge), .tick(tick), .t(o2_t)
  );
  assign o2 = o2_t;
`else
  assign o2 = '0;
`endif

  for (genvar i = 0; i < N_SYN; i++) begin : g_lane
    bcm_stdp_lane #(
      .W(W_WIDTH), .INC(TRACE_INC), .TAU_SHIFT(TAU_SHIFT),
      .AP(A_PLUS_SHIFT), .AM(A_MINUS_SHIFT), .TRIP_SH(FRAC + A_PLUS_SHIFT),
      .W_INIT(W_INIT), .W_MIN(W_MIN), .W_MAX(W_MAX)
    ) u_lane (
      .clk(clk), .rst(rst), .learn_en(learn_en),
      .pre_edge(pre_edge[i]), .post_edge(post_edge), .tick(tick),
      .o1(o1_t),
`ifdef BCM_STDP_TRIPLET_EN
      .o2(o2_t),
`endif
      .w(w_bus[i*W_WIDTH +: W_WIDTH]),
      .r1(r1_bus[i*W_WIDTH +: W_WIDTH]),
      .chg(chg[i])
    );
  end
endmodule

// File: tb/tb_bcm_stdp_array.sv
// Scoreboard bench for bcm_stdp_array: default instance plus a DECAY_DIV=4 instance sharing stimulus.
module tb_bcm_stdp_array;
  localparam int N = 4;
  localparam int W = 18;
  localparam int K_W = 0, K_R1 = 1, K_O1 = 2, K_O2 = 3, K_UPD = 4, K_R1D4 = 5;

  typedef struct {
    string tag;
    int    kind;
    int    idx;
    int    exp;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, learn_en, post;
  logic [N-1:0]   pre;
  logic [N*W-1:0] w_bus, r1_bus, w_bus4, r1_bus4;
  logic [W-1:0]   o1, o2, o1_4, o2_4;
  logic           upd, upd4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcm_stdp_array dut (
    .clk(clk), .rst(rst), .learn_en(learn_en), .pre(pre), .post(post),
    .w_bus(w_bus), .r1_bus(r1_bus), .o1(o1), .o2(o2), .upd_valid(upd)
  );

  bcm_stdp_array #(.DECAY_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .learn_en(learn_en), .pre(pre), .post(post),
    .w_bus(w_bus4), .r1_bus(r1_bus4), .o1(o1_4), .o2(o2_4), .upd_valid(upd4)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int obs(input int kind, input int idx);
    case (kind)
      K_W:    return int'($signed(w_bus[idx*W +: W]));
      K_R1:   return int'($signed(r1_bus[idx*W +: W]));
      K_O1:   return int'($signed(o1));
      K_O2:   return int'($signed(o2));
      K_UPD:  return int'(upd);
      K_R1D4: return int'($signed(r1_bus4[idx*W +: W]));
      default: return -999999;
    endcase
  endfunction

  task automatic expv(input string tag, input int kind, input int idx, input int v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  // Advance one clock, then score everything queued for this edge.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chg_chk: chk(e.tag, obs(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic exp_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      expv({tag, "_w"}, K_W, i, 4096);
      expv({tag, "_r1"}, K_R1, i, 0);
    end
    expv({tag, "_o1"}, K_O1, 0, 0);
    expv({tag, "_o2"}, K_O2, 0, 0);
    expv({tag, "_upd"}, K_UPD, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; pre = '0; post = 1'b0;
    exp_reset("rst");
    cyc();
    rst = 1'b0;
  endtask

  function automatic int trace_step(input int e, input bit spk, input bit tk, input int sh);
    int d;
    d = tk ? (e >>> sh) : 0;
    if (tk && e > 0 && d == 0) d = 1;
    e = e - d + (spk ? 1024 : 0);
    if (e < 0) e = 0;
    if (e > 131071) e = 131071;
    return e;
  endfunction

  initial begin
    int m1, m4, cnt;
    bit tk4;
    rst = 1'b1; learn_en = 1'b1; pre = '0; post = 1'b0;

    // reset held three cycles
    cyc(); cyc();
    exp_reset("rst3");
    cyc();
    rst = 1'b0;

    // pre-before-post potentiation
    pre = 4'b0001;
    expv("pbp_r1", K_R1, 0, 1024); expv("pbp_w0a", K_W, 0, 4096); expv("pbp_upd0", K_UPD, 0, 0);
    cyc();
    pre = '0; post = 1'b1;
    expv("pbp_w0", K_W, 0, 4160); expv("pbp_r1b", K_R1, 0, 896); expv("pbp_o1", K_O1, 0, 1024);
    expv("pbp_w1", K_W, 1, 4096); expv("pbp_w3", K_W, 3, 4096); expv("pbp_upd", K_UPD, 0, 1);
    cyc();
    post = 1'b0;
    expv("pbp_updoff", K_UPD, 0, 0); expv("pbp_o1b", K_O1, 0, 896); expv("pbp_r1c", K_R1, 0, 784);
    cyc();

    // post-before-pre depression
    do_reset();
    post = 1'b1;
    expv("ptp_o1", K_O1, 0, 1024); expv("ptp_w2a", K_W, 2, 4096);
    cyc();
    post = 1'b0; pre = 4'b0100;
    expv("ptp_w2", K_W, 2, 4064); expv("ptp_w0", K_W, 0, 4096); expv("ptp_w1", K_W, 1, 4096);
    expv("ptp_w3", K_W, 3, 4096); expv("ptp_upd", K_UPD, 0, 1); expv("ptp_r12", K_R1, 2, 1024);
    cyc();
    pre = '0;
    expv("ptp_updoff", K_UPD, 0, 0);
    cyc();

    // decay to zero, DECAY_DIV=1 and DECAY_DIV=4 side by side
    do_reset();
    m1 = 0; m4 = 0; cnt = 0;
    for (int c = 0; c < 60; c++) begin
      pre = (c == 0) ? 4'b0010 : 4'b0000;
      tk4 = (cnt == 3);
      cnt = tk4 ? 0 : cnt + 1;
      m1 = trace_step(m1, c == 0, 1'b1, 3);
      m4 = trace_step(m4, c == 0, tk4, 3);
      expv("dec_r1", K_R1, 1, m1);
      expv("dec4_r1", K_R1D4, 1, m4);
      cyc();
    end
    expv("dec_zero", K_R1, 1, 0);
    cyc();

    // held-high pre counts once
    do_reset();
    m1 = 0;
    pre = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      m1 = trace_step(m1, c == 0, 1'b1, 3);
      expv("lvl_r1", K_R1, 0, m1);
      cyc();
    end
    pre = '0;

    // simultaneous pairs drive W[0] to the upper clamp
    do_reset();
    for (int p = 0; p < 200; p++) begin
      pre = 4'b0001; post = 1'b1;
      if (p == 0) expv("clp_first", K_W, 0, 4096);
      cyc();
      pre = '0; post = 1'b0;
      cyc();
    end
    for (int p = 0; p < 3; p++) begin
      pre = 4'b0001; post = 1'b1;
      expv("clp_w0", K_W, 0, 16384); expv("clp_upd", K_UPD, 0, 0); expv("clp_w1", K_W, 1, 4096);
      cyc();
      pre = '0; post = 1'b0;
      expv("clp_w0b", K_W, 0, 16384); expv("clp_updb", K_UPD, 0, 0);
      cyc();
    end

    // learn_en low: traces move, weights frozen
    do_reset();
    learn_en = 1'b0;
    pre = 4'b0001;
    expv("nle_r1", K_R1, 0, 1024);
    cyc();
    pre = '0; post = 1'b1;
    expv("nle_w0", K_W, 0, 4096); expv("nle_r1b", K_R1, 0, 896);
    expv("nle_o1", K_O1, 0, 1024); expv("nle_upd", K_UPD, 0, 0);
    cyc();
    post = 1'b0; learn_en = 1'b1;
    cyc();

    // reset mid-stream discards the in-flight update
    do_reset();
    pre = 4'b0001;
    cyc();
    pre = '0; post = 1'b1;
    expv("mid_w0", K_W, 0, 4160);
    cyc();
    post = 1'b0; pre = 4'b0001; rst = 1'b1;
    exp_reset("mid");
    cyc();
    rst = 1'b0; pre = '0;
    expv("mid_hold", K_W, 0, 4096);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
